// File: rtl/rns2bin_32_31_21_5.sv
// Sequential mixed-radix RNS-to-binary converter for the moduli set (32, 31, 21, 5).
// Accepts one residue tuple, emits X in [0, 104159] after four digit/sum steps.
module rns2bin_32_31_21_5 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  res_1,
  input  logic [4:0]  res_2,
  input  logic [4:0]  res_3,
  input  logic [2:0]  res_4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] bin_out,
  output logic        ovf,
  output logic        err
);

  localparam int MOD_1 = 32;
  localparam int MOD_2 = 31;
  localparam int MOD_3 = 21;
  localparam int MOD_4 = 5;
  localparam int OUT_W = 17;

  // Mixed-radix weights and the modular inverses of the weights.
  localparam int W_3   = MOD_1 * MOD_2;          // 992
  localparam int W_4   = W_3 * MOD_3;            // 20832
  localparam int INV_3 = 17;                     // (992 mod 21)^-1 mod 21
  localparam int INV_4 = 3;                      // (20832 mod 5)^-1 mod 5
  // Biases are multiples of the modulus large enough to keep differences non-negative.
  localparam int BIAS_3 = 48 * MOD_3;            // 1008 > 31 + 32*30
  localparam int BIAS_4 = 4167 * MOD_4;          // 20835 > 31 + 32*30 + 992*20

  typedef enum logic [2:0] {
    S_IDLE,
    S_A2,
    S_A3,
    S_A4,
    S_SUM,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [4:0]       r1_q, r1_d;
  logic [4:0]       r2_q, r2_d;
  logic [4:0]       r3_q, r3_d;
  logic [2:0]       r4_q, r4_d;
  logic             err_r_q, err_r_d;
  logic [4:0]       a2_q, a2_d;
  logic [4:0]       a3_q, a3_d;
  logic [2:0]       a4_q, a4_d;
  logic [OUT_W-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic [4:0]       a2_w;
  logic [4:0]       a3_w;
  logic [2:0]       a4_w;
  logic [OUT_W-1:0] x_w;

  // Digit a1 is r1 itself; each later digit is computed at full 32-bit width
  // and only narrowed after its final reduction.
  assign a2_w = 5'((32'(r2_q) + MOD_2 - 32'(r1_q) % MOD_2) % MOD_2);
  assign a3_w = 5'((((32'(r3_q) + BIAS_3 - 32'(r1_q) - MOD_1 * 32'(a2_q)) % MOD_3)
                    * INV_3) % MOD_3);
  assign a4_w = 3'((((32'(r4_q) + BIAS_4 - 32'(r1_q) - MOD_1 * 32'(a2_q)
                      - W_3 * 32'(a3_q)) % MOD_4) * INV_4) % MOD_4);
  assign x_w  = OUT_W'(r1_q) + OUT_W'(a2_q) * OUT_W'(MOD_1)
              + OUT_W'(a3_q) * OUT_W'(W_3) + OUT_W'(a4_q) * OUT_W'(W_4);

  // NOTE: every signal written below gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    r4_d        = r4_q;
    err_r_d     = err_r_q;
    a2_d        = a2_q;
    a3_d        = a3_q;
    a4_d        = a4_q;
    bin_d       = bin_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          r1_d    = res_1;
          r2_d    = res_2;
          r3_d    = res_3;
          r4_d    = res_4;
          err_r_d = (32'(res_2) == MOD_2) | (32'(res_3) >= MOD_3) | (32'(res_4) >= MOD_4);
          state_d = S_A2;
        end
      end
      S_A2: begin
        a2_d    = a2_w;
        state_d = S_A3;
      end
      S_A3: begin
        a3_d    = a3_w;
        state_d = S_A4;
      end
      S_A4: begin
        a4_d    = a4_w;
        state_d = S_SUM;
      end
      S_SUM: begin
        if (err_r_q) begin
          bin_d = '0;
          ovf_d = 1'b0;
          err_d = 1'b1;
        end else begin
          bin_d = x_w;
          ovf_d = (x_w >= OUT_W'(65536));
          err_d = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      r4_q        <= '0;
      err_r_q     <= 1'b0;
      a2_q        <= '0;
      a3_q        <= '0;
      a4_q        <= '0;
      bin_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      r4_q        <= r4_d;
      err_r_q     <= err_r_d;
      a2_q        <= a2_d;
      a3_q        <= a3_d;
      a4_q        <= a4_d;
      bin_q       <= bin_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rns2bin_32_31_21_5.sv
// Self-checking bench for rns2bin_32_31_21_5: directed corner tuples plus random
// tuples checked against a CRT search model, handshake stalls and mid-flight reset.
module tb_rns2bin_32_31_21_5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  res_1, res_2, res_3;
  logic [2:0]  res_4;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] bin_out;
  logic        ovf;
  logic        err;

  int total = 0;
  int bad   = 0;

  rns2bin_32_31_21_5 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_1     (res_1),
    .res_2     (res_2),
    .res_3     (res_3),
    .res_4     (res_4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: illegal tuples flag err; legal ones are found by searching the
  // integers congruent to r1 mod 32 for the unique match of the other moduli.
  function automatic void ref_conv(input int r1, input int r2, input int r3, input int r4,
                                   output int x, output bit e);
    e = (r2 >= 31) || (r3 >= 21) || (r4 >= 5);
    x = 0;
    if (!e) begin
      for (int k = 0; k < 3255; k++) begin
        int c;
        c = r1 + 32 * k;
        if ((c % 31 == r2) && (c % 21 == r3) && (c % 5 == r4)) begin
          x = c;
          break;
        end
      end
    end
  endfunction

  task automatic start(input int r1, input int r2, input int r3, input int r4);
    check("in_ready_idle", 32'(in_ready), 1);
    res_1    = 5'(r1);
    res_2    = 5'(r2);
    res_3    = 5'(r3);
    res_4    = 3'(r4);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("in_ready_busy", 32'(in_ready), 0);
  endtask

  // Called #1 after the accepting edge T; checks out_valid is low through T+3
  // and the result appears right after T+4.
  task automatic wait_result(input string tag, input int r1, input int r2,
                             input int r3, input int r4);
    int x;
    bit e;
    ref_conv(r1, r2, r3, r4, x, e);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_early_valid"}, 32'(out_valid), 0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_bin"}, 32'(bin_out), e ? 0 : x);
    check({tag, "_ovf"}, 32'(ovf), (!e && x >= 65536) ? 1 : 0);
    check({tag, "_err"}, 32'(err), e ? 1 : 0);
    check({tag, "_rdy_low"}, 32'(in_ready), 0);
  endtask

  task automatic accept;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("acc_valid_low", 32'(out_valid), 0);
    check("acc_rdy_high", 32'(in_ready), 1);
  endtask

  task automatic convert(input string tag, input int r1, input int r2,
                         input int r3, input int r4);
    start(r1, r2, r3, r4);
    wait_result(tag, r1, r2, r3, r4);
    accept();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    res_1     = '0;
    res_2     = '0;
    res_3     = '0;
    res_4     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_bin", 32'(bin_out), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    convert("d1000", 8, 8, 13, 0);
    convert("dzero", 0, 0, 0, 0);
    convert("d65535", 31, 1, 15, 0);
    convert("d65536", 0, 2, 16, 1);
    convert("dmax", 31, 30, 20, 4);
    convert("derr2", 0, 31, 0, 0);
    convert("derr3", 0, 0, 21, 0);
    convert("derr4", 3, 4, 5, 7);

    // Random tuples: mostly legal ones derived from a random X, some raw residues.
    for (int i = 0; i < 40; i++) begin
      int r1, r2, r3, r4;
      if ($urandom_range(0, 9) < 8) begin
        int xr;
        xr = int'($urandom_range(0, 104159));
        r1 = xr % 32;
        r2 = xr % 31;
        r3 = xr % 21;
        r4 = xr % 5;
      end else begin
        r1 = int'($urandom_range(0, 31));
        r2 = int'($urandom_range(0, 31));
        r3 = int'($urandom_range(0, 31));
        r4 = int'($urandom_range(0, 7));
      end
      convert("rnd", r1, r2, r3, r4);
    end

    // Consumer stalls in DONE; a tuple offered meanwhile must be ignored.
    start(0, 2, 16, 1);
    wait_result("hold", 0, 2, 16, 1);
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin
        res_1    = 5'd8;
        res_2    = 5'd8;
        res_3    = 5'd13;
        res_4    = 3'd0;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_bin", 32'(bin_out), 65536);
      check("hold_ovf", 32'(ovf), 1);
      check("hold_err", 32'(err), 0);
      check("hold_rdy", 32'(in_ready), 0);
    end
    accept();
    @(posedge clk);
    #1;
    check("hold_not_captured", 32'(in_ready), 1);
    check("hold_no_valid", 32'(out_valid), 0);

    // Reset while in A3 after leaving a nonzero result on the outputs.
    convert("pre_rst", 31, 30, 20, 4);
    start(8, 8, 13, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_bin", 32'(bin_out), 0);
    check("midrst_ovf", 32'(ovf), 0);
    check("midrst_rdy", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    convert("post_rst", 8, 8, 13, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", total, 0);
    $fatal(1, "time limit reached");
  end

endmodule
